// File: rtl/recursion_controller.sv
// recursion_controller
//   Iterative evaluator of f(n) = f(n-2) + f(n-3), with f(0) = f(1) = f(2) = 1.
//   Hardware recursion is replaced by an explicit LIFO of pending arguments.
//   The controller pops an argument and tests it for the base case. A base case
//   adds one to the accumulator. Any other argument pushes n-2 and then n-3.
//   The final accumulator value is the count of base-case leaves, which is f(n).
//
// Parameters
//   SIZE   width of the argument n and of each stack entry
//   RW     width of the result accumulator (wraps modulo 2^RW)
//   DEPTH  number of stack entries, must be >= 2
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   start   request, sampled only in IDLE
//   n       argument, latched on the accepted start
//   result  f(n), valid while done=1 and held until the next completion
//   done    one-cycle completion pulse
//   busy    high in every state except IDLE
//   err     stack overflow flag, set with done, cleared by the next accepted start
module recursion_controller #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned RW    = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] n,
    output logic [RW-1:0]   result,
    output logic            done,
    output logic            busy,
    output logic            err
);

    // sp ranges over 0..DEPTH, so it needs one more code than the address.
    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        CHECK,
        PUSH_A,
        PUSH_B,
        FIN
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [SPW-1:0]  sp;
    logic [SPW-1:0]  sp_d;
    logic [SIZE-1:0] cur;
    logic [SIZE-1:0] cur_d;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   acc_d;
    logic [RW-1:0]   result_d;
    logic            done_d;
    logic            busy_d;
    logic            err_d;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [SIZE-1:0] wr_data;
    logic [AW-1:0]   rd_addr;
    logic [SIZE-1:0] stack [DEPTH];

    // Top-of-stack address. This value is only used when sp > 0.
    assign rd_addr = AW'(sp - SPW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, datapath updates, and stack write request
    always_comb begin
        state_d  = state;
        sp_d     = sp;
        cur_d    = cur;
        acc_d    = acc;
        err_d    = err;
        result_d = result;
        wr_en    = 1'b0;
        wr_addr  = AW'(sp);
        wr_data  = cur;

        case (state)
            IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = n;
                    sp_d    = SPW'(1);
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (sp == '0) begin
                    state_d = FIN;
                end else begin
                    cur_d   = stack[rd_addr];
                    sp_d    = sp - SPW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cur <= SIZE'(2)) begin
                    acc_d   = acc + RW'(1);
                    state_d = EVAL;
                end else begin
                    state_d = PUSH_A;
                end
            end
            PUSH_A: begin
                if (sp == SPW'(DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = cur - SIZE'(2);
                    sp_d    = sp + SPW'(1);
                    state_d = PUSH_B;
                end
            end
            PUSH_B: begin
                if (sp == SPW'(DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wr_en   = 1'b1;
                    wr_data = cur - SIZE'(3);
                    sp_d    = sp + SPW'(1);
                    state_d = EVAL;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The registered outputs track the state being entered, so done, err
        // and result line up with the FIN cycle itself.
        done_d = (state_d == FIN);
        busy_d = (state_d != IDLE);
        if (state_d == FIN) begin
            result_d = acc_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sp     <= '0;
            cur    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            sp     <= sp_d;
            cur    <= cur_d;
            acc    <= acc_d;
            result <= result_d;
            done   <= done_d;
            busy   <= busy_d;
            err    <= err_d;
        end
    end

    // Argument stack as a flop array with no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            stack[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_recursion_controller.sv
// tb_recursion_controller
//   Drives two instances: "a" uses the default DEPTH=16 and "b" uses DEPTH=2
//   to exercise overflow. Each result is compared against constants or
//   against a queue-based model of the recurrence.
module tb_recursion_controller;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic [3:0]  n_a;
    logic [15:0] result_a;
    logic        done_a;
    logic        busy_a;
    logic        err_a;
    logic        start_b;
    logic [3:0]  n_b;
    logic [15:0] result_b;
    logic        done_b;
    logic        busy_b;
    logic        err_b;

    int total = 0;
    int bad   = 0;

    recursion_controller #(.SIZE(4), .RW(16), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .n(n_a),
        .result(result_a), .done(done_a), .busy(busy_a), .err(err_a)
    );

    recursion_controller #(.SIZE(4), .RW(16), .DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .n(n_b),
        .result(result_b), .done(done_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int n;
        int res;
        int edges;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic get_done(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? err_b : err_a;
    endfunction

    function automatic int get_res(input bit sel);
        return sel ? int'(result_b) : int'(result_a);
    endfunction

    task automatic drive(input bit sel, input logic s, input int nv);
        if (sel) begin
            start_b = s;
            n_b     = 4'(nv);
        end else begin
            start_a = s;
            n_a     = 4'(nv);
        end
    endtask

    // Walks the call tree with an explicit queue stack and tallies edges by pop type.
    function automatic void model(input int nv, input int depth, output int leaves,
                                  output bit e, output int edges);
        int stk[$];
        int c;
        stk.push_back(nv);
        leaves = 0;
        e      = 1'b0;
        edges  = 1;
        forever begin
            if (stk.size() == 0) begin
                edges += 1;
                break;
            end
            c = stk.pop_back();
            if (c <= 2) begin
                leaves++;
                edges += 2;
                continue;
            end
            if (stk.size() == depth) begin
                e = 1'b1;
                edges += 3;
                break;
            end
            stk.push_back(c - 2);
            if (stk.size() == depth) begin
                e = 1'b1;
                edges += 4;
                break;
            end
            stk.push_back(c - 3);
            edges += 4;
        end
    endfunction

    // Issues one start and waits for done. Edges are counted from the sampling edge.
    // If poke_at is nonzero, start is re-pulsed with n=4 after that edge while busy.
    task automatic run_op(input bit sel, input int nv, input int poke_at,
                          output int res, output bit e, output int edges,
                          output int busy_drops);
        @(negedge clk);
        drive(sel, 1'b1, nv);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, nv);
        edges      = 1;
        busy_drops = 0;
        while (!get_done(sel) && edges < 2000) begin
            if (!get_busy(sel)) busy_drops++;
            if (poke_at != 0 && edges == poke_at) drive(sel, 1'b1, 4);
            else drive(sel, 1'b0, 4);
            @(posedge clk);
            #1;
            edges++;
        end
        drive(sel, 1'b0, 0);
        if (!get_done(sel)) chk("done_timeout", 0, 1);
        res = get_res(sel);
        e   = get_err(sel);
        @(posedge clk);
        #1;
        chk("done_one_cycle", get_done(sel), 0);
        chk("busy_after_fin", get_busy(sel), 0);
    endtask

    vec_t vecs[16];

    initial begin
        int  res;
        bit  e;
        int  edges;
        int  drops;
        int  m_leaves;
        bit  m_err;
        int  m_edges;

        vecs = '{
            '{0, 1, 4},    '{1, 1, 4},    '{2, 1, 4},    '{3, 2, 10},
            '{4, 2, 10},   '{5, 3, 16},   '{6, 4, 22},   '{7, 5, 28},
            '{8, 7, 40},   '{9, 9, 52},   '{10, 12, 70}, '{11, 16, 94},
            '{12, 21, 124},'{13, 28, 166},'{14, 37, 220},'{15, 49, 292}
        };

        rst = 1'b1;
        start_a = 1'b0;
        n_a = '0;
        start_b = 1'b0;
        n_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_result", result_a, 0);
        rst = 1'b0;

        // Full sweep against the table
        foreach (vecs[i]) begin
            run_op(1'b0, vecs[i].n, 0, res, e, edges, drops);
            chk($sformatf("sweep_res_n%0d", vecs[i].n), res, vecs[i].res);
            chk($sformatf("sweep_err_n%0d", vecs[i].n), e, 0);
            chk($sformatf("sweep_edges_n%0d", vecs[i].n), edges, vecs[i].edges);
            chk($sformatf("sweep_busy_n%0d", vecs[i].n), drops, 0);
        end

        // Restarting while busy must be ignored
        run_op(1'b0, 15, 50, res, e, edges, drops);
        chk("poke_res", res, 49);
        chk("poke_edges", edges, 292);
        chk("poke_busy", drops, 0);

        // Reset in the middle of an n=9 run
        @(negedge clk);
        drive(1'b0, 1'b1, 9);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_err", err_a, 0);
        chk("midrst_result", result_a, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(1'b0, 0, 0, res, e, edges, drops);
        chk("after_rst_res", res, 1);
        chk("after_rst_edges", edges, 4);

        // Hold start high: the FIN->IDLE cycle ignores start, and the next IDLE cycle accepts it
        @(negedge clk);
        drive(1'b0, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_done1", done_a, 1);
        @(posedge clk);
        #1;
        chk("b2b_idle_busy", busy_a, 0);
        chk("b2b_idle_done", done_a, 0);
        @(posedge clk);
        #1;
        chk("b2b_accept", busy_a, 1);
        drive(1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_done2", done_a, 1);
        chk("b2b_res2", result_a, 1);
        @(posedge clk);
        #1;

        // Overflow with DEPTH=2
        run_op(1'b1, 6, 0, res, e, edges, drops);
        model(6, 2, m_leaves, m_err, m_edges);
        chk("ovf_err", e, 1);
        chk("ovf_edges", edges, m_edges);
        chk("ovf_err_held", err_b, 1);
        run_op(1'b1, 3, 0, res, e, edges, drops);
        chk("ovf_clear_err", e, 0);
        chk("ovf_clear_res", res, 2);
        chk("ovf_clear_edges", edges, 10);

        // Random stimulus against the model
        for (int k = 0; k < 40; k++) begin
            bit sel;
            int nv;
            int poke;
            sel  = 1'($urandom_range(0, 1));
            nv   = int'($urandom_range(0, 15));
            poke = int'($urandom_range(0, 6));
            model(nv, sel ? 2 : 16, m_leaves, m_err, m_edges);
            run_op(sel, nv, poke, res, e, edges, drops);
            chk($sformatf("rnd%0d_err_s%0d_n%0d", k, sel, nv), e, m_err);
            chk($sformatf("rnd%0d_edges_s%0d_n%0d", k, sel, nv), edges, m_edges);
            chk($sformatf("rnd%0d_busy_s%0d_n%0d", k, sel, nv), drops, 0);
            if (!m_err) chk($sformatf("rnd%0d_res_s%0d_n%0d", k, sel, nv), res, m_leaves % 65536);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
